// File: rtl/ysyx_22041207_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041207_decode_pkg
// Description : Shared types and constants for the RV32/RV64 decode stage:
//               ALU / write-back selectors, opcodes, exception causes and
//               the packed control bundle handed to EX.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041207_decode_pkg;

  typedef enum logic [4:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_RETURN_A, ALU_RETURN_B
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_CSR, WB_SEXT32
  } wb_sel_e;

  // Operand A / B source selectors
  localparam logic [1:0] c_SEL_A_RS1  = 2'd0;
  localparam logic [1:0] c_SEL_A_PC   = 2'd1;
  localparam logic [1:0] c_SEL_A_ZERO = 2'd2;
  localparam logic [1:0] c_SEL_B_RS2  = 2'd0;
  localparam logic [1:0] c_SEL_B_IMM  = 2'd1;
  localparam logic [1:0] c_SEL_B_FOUR = 2'd2;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] c_OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
  localparam logic [6:0] c_OPC_OP       = 7'b0110011;
  localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
  localparam logic [6:0] c_OPC_OP32     = 7'b0111011;
  localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
  localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
  localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

  // Exception cause codes
  localparam logic [3:0] c_CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] c_CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] c_CAUSE_ECALL_M = 4'd11;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    wb_sel_e    wb_sel;
    logic       rd_wen;
    logic       mem_ren;
    logic [7:0] mem_mask;
    logic       load_sext;
    logic       word_op;
    logic       jump;
    logic       jalr;
    logic       branch_taken;
    logic       csr_wen;
    logic       is_mret;
    logic       is_ebreak;
  } decode_ctrl_t;

  localparam int CTRL_W = $bits(decode_ctrl_t);

endpackage
`default_nettype wire

// File: rtl/ysyx_22041207_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041207_imm_gen
// Description : Combinational immediate extraction (I/S/B/U/J), sign-extended
//               to XLEN. Format is chosen from the major opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041207_imm_gen
  import ysyx_22041207_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  // Build the 32-bit immediate for the instruction's format
  always_comb begin
    w_imm32 = '0;
    case (i_inst[6:0])
      c_OPC_LOAD, c_OPC_OP_IMM, c_OPC_OP_IMM32, c_OPC_JALR, c_OPC_SYSTEM:
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      c_OPC_STORE:
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      c_OPC_BRANCH:
        w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                   i_inst[11:8], 1'b0};
      c_OPC_LUI, c_OPC_AUIPC:
        w_imm32 = {i_inst[31:12], 12'b0};
      c_OPC_JAL:
        w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                   i_inst[30:21], 1'b0};
      default:
        w_imm32 = '0;
    endcase
  end

  // Widening a signed value sign-extends, so U-type also extends on RV64
  assign o_imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/ysyx_22041207_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041207_decode_stage
// Description : RV32/RV64 decode stage. Decodes the IF instruction, resolves
//               branches against regfile data and registers the bundle for
//               EX behind a valid/ready handshake with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041207_decode_stage
  import ysyx_22041207_decode_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit HAS_M   = 1'b1,
  parameter bit HAS_CSR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_inst,
  input  logic [XLEN-1:0]   if_pc,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              id_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_imm,
  output logic [XLEN-1:0]   id_rs1,
  output logic [XLEN-1:0]   id_rs2,
  output logic [4:0]        id_rd,
  output logic [CTRL_W-1:0] id_ctrl,
  output logic              id_exc_valid,
  output logic [3:0]        id_exc_cause
);

  localparam bit c_RV32 = (XLEN == 32);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm;
  logic            w_taken;
  logic            w_illegal;
  logic            w_ecall;
  logic            w_ebreak;
  logic            w_exc;
  logic [3:0]      w_cause;
  logic            w_accept;
  decode_ctrl_t    w_ctrl;

  assign w_opcode = if_inst[6:0];
  assign w_funct3 = if_inst[14:12];
  assign w_funct7 = if_inst[31:25];
  assign w_rd     = if_inst[11:7];
  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];

  assign if_ready = !id_valid || ex_ready;
  assign w_accept = if_valid && if_ready && !flush;

  ysyx_22041207_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_inst (if_inst),
    .o_imm  (w_imm)
  );

  // Branch condition from funct3 (010/011 are rejected by the decoder)
  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = (rs1_data == rs2_data);
      3'b001:  w_taken = (rs1_data != rs2_data);
      3'b100:  w_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  w_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  w_taken = (rs1_data <  rs2_data);
      3'b111:  w_taken = (rs1_data >= rs2_data);
      default: w_taken = 1'b0;
    endcase
  end

  // Control decode, exception detection and side-effect suppression
  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    w_ecall   = 1'b0;
    w_ebreak  = 1'b0;
    case (w_opcode)
      c_OPC_LUI: begin
        w_ctrl.alu_op = ALU_RETURN_B; w_ctrl.sel_b = c_SEL_B_IMM; w_ctrl.rd_wen = 1'b1;
      end
      c_OPC_AUIPC: begin
        w_ctrl.alu_op = ALU_ADD; w_ctrl.sel_a = c_SEL_A_PC;
        w_ctrl.sel_b = c_SEL_B_IMM; w_ctrl.rd_wen = 1'b1;
      end
      c_OPC_JAL, c_OPC_JALR: begin
        // ALU computes the target; rd receives pc+4
        w_ctrl.alu_op = ALU_ADD; w_ctrl.sel_b = c_SEL_B_IMM;
        w_ctrl.jump = 1'b1; w_ctrl.rd_wen = 1'b1; w_ctrl.wb_sel = WB_PC4;
        if (w_opcode == c_OPC_JAL) w_ctrl.sel_a = c_SEL_A_PC;
        else begin
          w_ctrl.jalr = 1'b1;
          if (w_funct3 != 3'b000) w_illegal = 1'b1;
        end
      end
      c_OPC_BRANCH: begin
        w_ctrl.alu_op = ALU_ADD; w_ctrl.sel_a = c_SEL_A_PC; w_ctrl.sel_b = c_SEL_B_IMM;
        w_ctrl.branch_taken = w_taken;
        if (w_funct3[2:1] == 2'b01) w_illegal = 1'b1;
      end
      c_OPC_LOAD: begin
        w_ctrl.alu_op = ALU_ADD; w_ctrl.sel_b = c_SEL_B_IMM; w_ctrl.mem_ren = 1'b1;
        w_ctrl.rd_wen = 1'b1; w_ctrl.wb_sel = WB_MEM; w_ctrl.load_sext = !w_funct3[2];
        w_ctrl.mem_mask = 8'hFF >> (4'd8 - (4'd1 << w_funct3[1:0]));
        if (w_funct3 == 3'b111) w_illegal = 1'b1;
        if (c_RV32 && (w_funct3 == 3'b011 || w_funct3 == 3'b110)) w_illegal = 1'b1;
      end
      c_OPC_STORE: begin
        w_ctrl.alu_op = ALU_ADD; w_ctrl.sel_b = c_SEL_B_IMM;
        w_ctrl.mem_mask = 8'hFF >> (4'd8 - (4'd1 << w_funct3[1:0]));
        if (w_funct3[2] || (c_RV32 && w_funct3 == 3'b011)) w_illegal = 1'b1;
      end
      c_OPC_OP_IMM: begin
        w_ctrl.sel_b = c_SEL_B_IMM; w_ctrl.rd_wen = 1'b1;
        case (w_funct3)
          3'b000: w_ctrl.alu_op = ALU_ADD;
          3'b010: w_ctrl.alu_op = ALU_SLT;
          3'b011: w_ctrl.alu_op = ALU_SLTU;
          3'b100: w_ctrl.alu_op = ALU_XOR;
          3'b110: w_ctrl.alu_op = ALU_OR;
          3'b111: w_ctrl.alu_op = ALU_AND;
          3'b001: begin
            w_ctrl.alu_op = ALU_SLL;
            if (if_inst[31:26] != 6'b000000) w_illegal = 1'b1;
          end
          default: begin
            if (if_inst[31:26] == 6'b000000)      w_ctrl.alu_op = ALU_SRL;
            else if (if_inst[31:26] == 6'b010000) w_ctrl.alu_op = ALU_SRA;
            else                                  w_illegal = 1'b1;
          end
        endcase
        // shamt[5] only exists on RV64
        if (c_RV32 && w_funct3[1:0] == 2'b01 && if_inst[25]) w_illegal = 1'b1;
      end
      c_OPC_OP, c_OPC_OP32: begin
        w_ctrl.rd_wen = 1'b1;
        if (w_opcode == c_OPC_OP32) begin
          w_ctrl.word_op = 1'b1; w_ctrl.wb_sel = WB_SEXT32;
          if (c_RV32) w_illegal = 1'b1;
        end
        case (w_funct7)
          7'b0000000: begin
            case (w_funct3)
              3'b000:  w_ctrl.alu_op = ALU_ADD;
              3'b001:  w_ctrl.alu_op = ALU_SLL;
              3'b010:  w_ctrl.alu_op = ALU_SLT;
              3'b011:  w_ctrl.alu_op = ALU_SLTU;
              3'b100:  w_ctrl.alu_op = ALU_XOR;
              3'b101:  w_ctrl.alu_op = ALU_SRL;
              3'b110:  w_ctrl.alu_op = ALU_OR;
              default: w_ctrl.alu_op = ALU_AND;
            endcase
            if (w_ctrl.word_op && w_funct3 != 3'b000 && w_funct3 != 3'b001 &&
                w_funct3 != 3'b101) w_illegal = 1'b1;
          end
          7'b0100000: begin
            if (w_funct3 == 3'b000)      w_ctrl.alu_op = ALU_SUB;
            else if (w_funct3 == 3'b101) w_ctrl.alu_op = ALU_SRA;
            else                         w_illegal = 1'b1;
          end
          7'b0000001: begin
            case (w_funct3)
              3'b100:  w_ctrl.alu_op = ALU_DIV;
              3'b101:  w_ctrl.alu_op = ALU_DIVU;
              3'b110:  w_ctrl.alu_op = ALU_REM;
              3'b111:  w_ctrl.alu_op = ALU_REMU;
              default: w_ctrl.alu_op = ALU_MUL;
            endcase
            if (!HAS_M || (w_ctrl.word_op && w_funct3[2:0] != 3'b000 && !w_funct3[2]))
              w_illegal = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      c_OPC_OP_IMM32: begin
        w_ctrl.sel_b = c_SEL_B_IMM; w_ctrl.rd_wen = 1'b1;
        w_ctrl.word_op = 1'b1; w_ctrl.wb_sel = WB_SEXT32;
        if (c_RV32) w_illegal = 1'b1;
        // W-shifts use shamt[4:0]; a set imm[5] is caught by the funct7 compare
        case (w_funct3)
          3'b000: w_ctrl.alu_op = ALU_ADD;
          3'b001: begin
            w_ctrl.alu_op = ALU_SLL;
            if (w_funct7 != 7'b0000000) w_illegal = 1'b1;
          end
          3'b101: begin
            if (w_funct7 == 7'b0000000)      w_ctrl.alu_op = ALU_SRL;
            else if (w_funct7 == 7'b0100000) w_ctrl.alu_op = ALU_SRA;
            else                             w_illegal = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      c_OPC_MISC_MEM: begin
        // fence / fence.i retire as no-ops in this in-order pipeline
        w_ctrl.alu_op = ALU_NONE;
      end
      c_OPC_SYSTEM: begin
        if (w_funct3 == 3'b000) begin
          if (if_inst == 32'h0000_0073)      w_ecall = 1'b1;
          else if (if_inst == 32'h0010_0073) begin w_ebreak = 1'b1; w_ctrl.is_ebreak = 1'b1; end
          else if (if_inst == 32'h3020_0073) w_ctrl.is_mret = 1'b1;
          else                               w_illegal = 1'b1;
        end else if (w_funct3 == 3'b100 || !HAS_CSR) begin
          w_illegal = 1'b1;
        end else begin
          w_ctrl.alu_op = ALU_RETURN_A; w_ctrl.csr_wen = 1'b1;
          w_ctrl.rd_wen = 1'b1; w_ctrl.wb_sel = WB_CSR;
        end
      end
      default: w_illegal = 1'b1;
    endcase

    if (if_inst[1:0] != 2'b11) w_illegal = 1'b1;

    w_exc   = w_illegal || w_ecall || w_ebreak;
    w_cause = w_illegal ? c_CAUSE_ILLEGAL :
              w_ebreak  ? c_CAUSE_BREAK   :
              w_ecall   ? c_CAUSE_ECALL_M : 4'd0;

    // A trapping instruction must leave no architectural side effect
    if (w_exc) begin
      w_ctrl.rd_wen = 1'b0; w_ctrl.mem_ren = 1'b0; w_ctrl.mem_mask = 8'h00;
      w_ctrl.csr_wen = 1'b0; w_ctrl.jump = 1'b0; w_ctrl.branch_taken = 1'b0;
    end
    if (w_rd == 5'd0) w_ctrl.rd_wen = 1'b0;
  end

  // ID/EX pipeline register: flush > accept > drain; hold while EX stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_imm       <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_rd        <= '0;
      id_ctrl      <= '0;
      id_exc_valid <= 1'b0;
      id_exc_cause <= '0;
    end else if (flush) begin
      id_valid     <= 1'b0;
      id_exc_valid <= 1'b0;
    end else if (w_accept) begin
      id_valid     <= 1'b1;
      id_pc        <= if_pc;
      id_imm       <= w_imm;
      id_rs1       <= rs1_data;
      id_rs2       <= rs2_data;
      id_rd        <= w_rd;
      id_ctrl      <= w_ctrl;
      id_exc_valid <= w_exc;
      id_exc_cause <= w_cause;
    end else if (ex_ready) begin
      id_valid     <= 1'b0;
      id_exc_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041207_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22041207_decode_stage
// Description : Directed self-checking bench: an RV64 (M, CSR) instance and
//               an RV32 instance without M share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041207_decode_stage;
  import ysyx_22041207_decode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, if_valid, flush, ex_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc, rs1_data, rs2_data;

  logic if_ready, id_valid, id_exc_valid;
  logic [4:0] rs1_addr, rs2_addr, id_rd;
  logic [63:0] id_pc, id_imm, id_rs1, id_rs2;
  logic [CTRL_W-1:0] id_ctrl;
  logic [3:0] id_exc_cause;

  logic if_ready32, id_valid32, id_exc_valid32;
  logic [4:0] rs1_addr32, rs2_addr32, id_rd32;
  logic [31:0] id_pc32, id_imm32, id_rs1_32, id_rs2_32;
  logic [CTRL_W-1:0] id_ctrl32;
  logic [3:0] id_exc_cause32;

  decode_ctrl_t c, c32;
  assign c   = decode_ctrl_t'(id_ctrl);
  assign c32 = decode_ctrl_t'(id_ctrl32);

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22041207_decode_stage #(.XLEN(64), .HAS_M(1'b1), .HAS_CSR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .id_valid(id_valid),
    .ex_ready(ex_ready), .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .id_exc_valid(id_exc_valid), .id_exc_cause(id_exc_cause)
  );

  ysyx_22041207_decode_stage #(.XLEN(32), .HAS_M(1'b0), .HAS_CSR(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready32),
    .if_inst(if_inst), .if_pc(if_pc[31:0]), .rs1_addr(rs1_addr32), .rs2_addr(rs2_addr32),
    .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]), .flush(flush),
    .id_valid(id_valid32), .ex_ready(ex_ready), .id_pc(id_pc32), .id_imm(id_imm32),
    .id_rs1(id_rs1_32), .id_rs2(id_rs2_32), .id_rd(id_rd32), .id_ctrl(id_ctrl32),
    .id_exc_valid(id_exc_valid32), .id_exc_cause(id_exc_cause32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst);
    if_inst = inst;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_inst = 32'h0000_0013; if_pc = '0;
    rs1_data = '0; rs2_data = '0; flush = 1'b0; ex_ready = 1'b1;
    tick(); tick();
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_ctrl", 64'(id_ctrl), 64'd0);
    chk("rst_imm", id_imm, 64'd0);
    chk("rst_exc", 64'(id_exc_valid), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    rst_n = 1'b1;

    // addi x1,x0,5
    if_valid = 1'b1; if_pc = 64'h100; if_inst = 32'h0050_0093; #1;
    chk("addi_rs2_addr", 64'(rs2_addr), 64'd5);
    tick();
    chk("addi_valid", 64'(id_valid), 64'd1);
    chk("addi_imm", id_imm, 64'd5);
    chk("addi_alu", 64'(c.alu_op), 64'(ALU_ADD));
    chk("addi_sel_b", 64'(c.sel_b), 64'(c_SEL_B_IMM));
    chk("addi_rd_wen", 64'(c.rd_wen), 64'd1);
    chk("addi_rd", 64'(id_rd), 64'd1);
    chk("addi_pc", id_pc, 64'h100);
    chk("addi_exc", 64'(id_exc_valid), 64'd0);

    // Branches
    rs1_data = 64'd7; rs2_data = 64'd7; issue(32'h0020_8463);
    chk("beq_eq_taken", 64'(c.branch_taken), 64'd1);
    chk("beq_imm", id_imm, 64'd8);
    chk("beq_rs1", id_rs1, 64'd7);
    rs2_data = 64'd8; issue(32'h0020_8463);
    chk("beq_ne_taken", 64'(c.branch_taken), 64'd0);
    rs1_data = '1; rs2_data = 64'd1; issue(32'h0020_E463);
    chk("bltu_taken", 64'(c.branch_taken), 64'd0);
    issue(32'h0020_C463);
    chk("blt_taken", 64'(c.branch_taken), 64'd1);
    chk("blt32_taken", 64'(c32.branch_taken), 64'd1);

    // EX stall: held bundle is the blt above
    ex_ready = 1'b0; if_inst = 32'h1234_52B7; rs1_data = '0; #1;
    chk("stall_if_ready", 64'(if_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 64'(id_valid), 64'd1);
      chk("stall_imm", id_imm, 64'd8);
      chk("stall_rs1", id_rs1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("stall_taken", 64'(c.branch_taken), 64'd1);
      chk("stall_if_ready_hold", 64'(if_ready), 64'd0);
    end
    ex_ready = 1'b1; #1;
    chk("unstall_if_ready", 64'(if_ready), 64'd1);
    tick();
    chk("lui_imm", id_imm, 64'h1234_5000);
    chk("lui_rd", 64'(id_rd), 64'd5);
    chk("lui_alu", 64'(c.alu_op), 64'(ALU_RETURN_B));
    issue(32'h8000_02B7);
    chk("lui_neg_imm", id_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_neg_imm32", 64'(id_imm32), 64'h8000_0000);

    // Loads / stores
    issue(32'hFFC1_2183);
    chk("lw_ren", 64'(c.mem_ren), 64'd1);
    chk("lw_mask", 64'(c.mem_mask), 64'h0F);
    chk("lw_sext", 64'(c.load_sext), 64'd1);
    chk("lw_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("lw_wb", 64'(c.wb_sel), 64'(WB_MEM));
    issue(32'h0001_3183);
    chk("ld_mask", 64'(c.mem_mask), 64'hFF);
    chk("ld32_exc", 64'(id_exc_valid32), 64'd1);
    chk("ld32_ren", 64'(c32.mem_ren), 64'd0);
    issue(32'h0020_A423);
    chk("sw_mask", 64'(c.mem_mask), 64'h0F);
    chk("sw_rd_wen", 64'(c.rd_wen), 64'd0);
    chk("sw_imm", id_imm, 64'd8);

    // Jumps
    issue(32'h0100_00EF);
    chk("jal_jump", 64'(c.jump), 64'd1);
    chk("jal_wb", 64'(c.wb_sel), 64'(WB_PC4));
    chk("jal_imm", id_imm, 64'd16);
    issue(32'h0000_90E7);
    chk("jalr_f3_exc", 64'(id_exc_valid), 64'd1);
    chk("jalr_f3_cause", 64'(id_exc_cause), 64'd2);
    chk("jalr_f3_jump", 64'(c.jump), 64'd0);

    // Word ops, M extension, shifts
    issue(32'h0020_81BB);
    chk("addw32_exc", 64'(id_exc_valid32), 64'd1);
    chk("addw32_cause", 64'(id_exc_cause32), 64'd2);
    chk("addw32_rd_wen", 64'(c32.rd_wen), 64'd0);
    chk("addw_exc", 64'(id_exc_valid), 64'd0);
    chk("addw_word_op", 64'(c.word_op), 64'd1);
    issue(32'h0220_81B3);
    chk("mul_nom_cause", 64'(id_exc_cause32), 64'd2);
    chk("mul_alu", 64'(c.alu_op), 64'(ALU_MUL));
    issue(32'h0200_909B);
    chk("slliw_imm5_exc", 64'(id_exc_valid), 64'd1);
    issue(32'h0200_9093);
    chk("slli64_alu", 64'(c.alu_op), 64'(ALU_SLL));
    chk("slli64_exc", 64'(id_exc_valid), 64'd0);
    chk("slli32_shamt5_exc", 64'(id_exc_valid32), 64'd1);
    issue(32'h0000_0000);
    chk("zero_inst_cause", 64'(id_exc_cause), 64'd2);
    chk("zero_inst_exc", 64'(id_exc_valid), 64'd1);
    issue(32'h0000_0013);
    chk("rd0_rd_wen", 64'(c.rd_wen), 64'd0);
    issue(32'h0000_0073);
    chk("ecall_exc", 64'(id_exc_valid), 64'd1);
    chk("ecall_cause", 64'(id_exc_cause), 64'd11);

    // Flush with the ecall held and addi x7,x0,9 offered
    flush = 1'b1; if_inst = 32'h0090_0393; #1;
    chk("flush_if_ready", 64'(if_ready), 64'd1);
    tick();
    chk("flush_valid", 64'(id_valid), 64'd0);
    chk("flush_exc", 64'(id_exc_valid), 64'd0);
    flush = 1'b0; if_valid = 1'b0;
    tick();
    chk("flush_discard", 64'(id_valid), 64'd0);

    // SYSTEM
    if_valid = 1'b1;
    issue(32'h0010_0073);
    chk("ebreak_flag", 64'(c.is_ebreak), 64'd1);
    chk("ebreak_cause", 64'(id_exc_cause), 64'd3);
    issue(32'h3020_0073);
    chk("mret_flag", 64'(c.is_mret), 64'd1);
    chk("mret_exc", 64'(id_exc_valid), 64'd0);
    issue(32'h3000_21F3);
    chk("csrrs_wen", 64'(c.csr_wen), 64'd1);
    chk("csrrs_wb", 64'(c.wb_sel), 64'(WB_CSR));
    chk("csrrs_rd_wen", 64'(c.rd_wen), 64'd1);
    if_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(id_valid), 64'd0);

    // Asynchronous reset between edges
    if_valid = 1'b1;
    issue(32'h0050_0093);
    chk("pre_rst_valid", 64'(id_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(id_valid), 64'd0);
    chk("async_rst_ctrl", 64'(id_ctrl), 64'd0);
    chk("async_rst_valid32", 64'(id_valid32), 64'd0);
    tick();
    chk("rst_hold_valid", 64'(id_valid), 64'd0);
    rst_n = 1'b1; if_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22041207_decode_stage.md
Name: ysyx_22041207_decode_stage

Overview:
Pipelined, parametrised RV32/RV64 instruction decode stage. It sits between IF and EX and performs the following:
- immediate generation;
- register-file address output;
- branch resolution;
- control-bundle generation;
- illegal/system-instruction exception detection.

All outputs to EX come from one pipeline register with a valid/ready handshake, plus flush.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64. With XLEN=32, OP-32/OP-IMM-32 opcodes and LD/LWU/SD are illegal.
HAS_M, 1, when 0, every funct7=0000001 encoding is illegal.
HAS_CSR, 1, when 0, every CSR funct3 (001,010,011,101,110,111) under SYSTEM is illegal.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF presents inst/pc
if_ready  out  1  stage can accept (combinational)
if_inst  in  32  instruction
if_pc  in  XLEN  instruction address
rs1_addr  out  5  if_inst[19:15], combinational to regfile
rs2_addr  out  5  if_inst[24:20], combinational to regfile
rs1_data  in  XLEN  regfile read, same cycle
rs2_data  in  XLEN  regfile read, same cycle
flush  in  1  kill held and incoming instruction
id_valid  out  1  bundle valid to EX
ex_ready  in  1  EX accepts bundle
id_pc, id_imm, id_rs1, id_rs2  out  XLEN  registered pc, sign-extended immediate, operand data
id_rd  out  5  destination register
id_ctrl  out  CTRL_W  packed decode_ctrl_t, holding:
- alu_op[4:0], sel_a[1:0], sel_b[1:0], wb_sel[2:0];
- rd_wen, mem_ren, mem_mask[7:0], load_sext, word_op;
- jump, jalr, branch_taken, csr_wen, is_mret, is_ebreak.
id_exc_valid  out  1  instruction raises exception
id_exc_cause  out  4  2 illegal, 3 breakpoint, 11 ecall-M

Behaviour:
- Reset (async, rst_n=0): id_valid=0; all id_* registers, id_ctrl and exception outputs are 0. Release is synchronous to clk.
- Handshake:
  - if_ready = !id_valid || ex_ready.
  - Accept when if_valid && if_ready && !flush. On accept, the register loads the decoded bundle next edge and id_valid=1.
  - If id_valid && ex_ready && no accept: id_valid=0 next edge.
  - If id_valid && !ex_ready: all id_* outputs hold stable; if_ready=0.
- Latency: exactly one cycle from accept to id_valid. Throughput is one instruction per cycle when ex_ready stays high.
- Flush has priority over everything:
  - next edge id_valid=0 and id_exc_valid=0;
  - an instruction offered in the flush cycle is discarded;
  - if_ready still follows the formula above.
- Immediate generation: I, S, B, U and J formats, sign-extended to XLEN. U-type is imm[31:12]<<12, sign-extended on RV64.
- Branches (funct3 000/001/100/101/110/111) compare rs1_data and rs2_data: signed for BLT/BGE, unsigned for BLTU/BGEU. The result is registered into branch_taken. Branch funct3 010/011 are illegal.
- Jumps: JAL sets jump=1, rd_wen=1, wb_sel=PC4. JALR additionally sets jalr=1 and requires funct3=000; other funct3 is illegal.
- Loads: mem_ren=1, alu_op=ADD. Byte count is encoded in mem_mask (01/03/0F/FF) and load_sext comes from funct3 bit 2. funct3=111 is illegal.
- Stores: mem_mask per size, rd_wen=0.
- Word ops: word_op=1 selects sign-extension of the 32-bit result. W-shifts use shamt[4:0]; slliw/srliw/sraiw with imm[5]=1 are illegal. RV64 shifts use shamt[5:0]; on RV32, shamt[5]=1 is illegal.
- SYSTEM instructions:
  - ecall (0x00000073) gives exc cause 11.
  - ebreak (0x00100073) gives is_ebreak=1 and cause 3.
  - mret (0x30200073) gives is_mret=1.
  - csrrw/csrrs/csrrc and the immediate variants give csr_wen=1, rd_wen=1, wb_sel=CSR.
  - Any other funct3=000 encoding is illegal.
- On any exception, force rd_wen=0, mem_ren=0, mem_mask=0, csr_wen=0, jump=0, branch_taken=0. Instructions with inst[1:0]!=11 and unknown opcodes are illegal.
- rd_wen is forced to 0 when rd=0.

Decomposition:
- Package ysyx_22041207_decode_pkg holds:
  - alu_op_e (NONE, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL, DIV, DIVU, REM, REMU, RETURN_A, RETURN_B);
  - wb_sel_e (ALU, MEM, PC4, CSR, SEXT32);
  - opcode constants, exception cause constants, decode_ctrl_t, CTRL_W.
- One sub-module, ysyx_22041207_imm_gen: combinational inst to XLEN immediate.
- The control decode stays inline in the stage.

Test Plan:
- addi x1,x0,5 (0x00500093), ex_ready=1 -> next cycle id_valid=1, id_imm=5, alu_op=ADD, sel_b=IMM, rd_wen=1, id_rd=1.
- beq x1,x2,+8 (0x00208463) with rs1=rs2=7 -> branch_taken=1, id_imm=8. Repeat with rs2=8 -> branch_taken=0. bltu with rs1=-1, rs2=1 -> branch_taken=0.
- id_valid=1 and ex_ready=0 held 3 cycles, new if_valid offered -> if_ready=0 and outputs unchanged; ex_ready=1 -> new instruction appears next cycle.
- flush with id_valid=1 and if_valid=1 -> next cycle id_valid=0, incoming instruction never appears. Assert rst_n low mid-stream -> id_valid=0 immediately, without waiting for an edge.
- XLEN=32 addw (0x002081BB) -> id_exc_valid=1, cause 2, rd_wen=0. HAS_M=0 mul (0x022081B3) -> cause 2. 0x00000000 -> cause 2.
- 0x00000073 -> cause 11. 0x00100073 -> is_ebreak=1, cause 3. 0x30200073 -> is_mret=1, id_exc_valid=0. csrrs x3,mstatus,x0 -> csr_wen=1, wb_sel=CSR.
